// File: rtl/program_loader.sv
// Byte-stream boot loader: writes a framed program image into RAM
// and holds the CPU in reset until the image checksum verifies.
module program_loader #(
    parameter int unsigned             ADDR_WIDTH    = 4,
    parameter int unsigned             DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0]   HEADER_BYTE   = 8'hA5,
    parameter bit                      HOLD_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        EVAL,
        DONE,
        ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic        accept;
    logic        is_hdr;
    logic        restart;
    logic [31:0] n_ext;

    // Handshake: stall only during the checksum evaluation cycle or reset.
    always_comb begin
        in_ready = reset && (state_q != EVAL);
        accept   = in_valid && in_ready;
        is_hdr   = accept && (in_data == HEADER_BYTE);
        n_ext    = 32'(in_data);
    end

    // Next-state and register updates for the frame parser.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        csum_d      = csum_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        restart     = 1'b0;

        unique case (state_q)
            IDLE: begin
                restart = is_hdr;
            end
            COUNT: begin
                if (accept) begin
                    if (n_ext == 32'd0 || n_ext > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        cnt_d   = n_ext[CW-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[ADDR_WIDTH-1:0];
                    ram_wdata_d = in_data;
                    sum_d       = sum_q + in_data;
                    idx_d       = idx_q + 1'b1;
                    if (idx_d == cnt_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    csum_d  = in_data;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d = (sum_q == csum_q) ? DONE : ERROR;
            end
            DONE: begin
                restart     = is_hdr;
                load_done_d = 1'b1;
                load_err_d  = 1'b0;
                cpu_hold_d  = 1'b0;
            end
            ERROR: begin
                restart     = is_hdr;
                load_err_d  = 1'b1;
                load_done_d = 1'b0;
                cpu_hold_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart) begin
            state_d     = COUNT;
            cpu_hold_d  = 1'b1;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            sum_d       = '0;
            idx_d       = '0;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            csum_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_hold_q  <= HOLD_AT_RESET;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            csum_q      <= csum_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame vectors from a table
// plus hand-written timing, stall and reset sequences.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int off;
        int len;
        int wr_off;
        int n_wr;
        bit done;
        bit err;
    } vec_t;

    logic [7:0] pool [$];
    vec_t       vecs [$];
    int         mark;

    int         total;
    int         passed;
    int         cyc;
    bit         both_seen;

    logic [3:0] wa [$];
    logic [7:0] wd [$];
    int         wc [$];
    logic [7:0] ram [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            wc.push_back(cyc);
            ram[ram_addr] = ram_wdata;
        end
        if (load_done && load_err) both_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: byte %0h not taken in 10 cycles", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_wr();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic close_vec(input int wr_off, input int n_wr,
                             input bit d, input bit e);
        vec_t v;
        v.off    = mark;
        v.len    = pool.size() - mark;
        v.wr_off = wr_off;
        v.n_wr   = n_wr;
        v.done   = d;
        v.err    = e;
        vecs.push_back(v);
        mark = pool.size();
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        clear_wr();
        for (int i = 0; i < v.len; i++) send(pool[v.off + i]);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d_done", k), 32'(load_done), 32'(v.done));
        chk($sformatf("v%0d_err", k), 32'(load_err), 32'(v.err));
        chk($sformatf("v%0d_hold", k), 32'(cpu_hold), 32'(!v.done));
        chk($sformatf("v%0d_nwr", k), wa.size(), v.n_wr);
        if (wa.size() == v.n_wr) begin
            for (int i = 0; i < v.n_wr; i++) begin
                chk($sformatf("v%0d_addr%0d", k, i), 32'(wa[i]), i);
                chk($sformatf("v%0d_data%0d", k, i), 32'(wd[i]),
                    32'(pool[v.off + v.wr_off + i]));
                chk($sformatf("v%0d_cyc%0d", k, i), wc[i], wc[0] + i);
            end
        end
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        cyc       = 0;
        mark      = 0;
        both_seen = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        reset     = 1'b0;

        pool = {pool, 8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        close_vec(2, 3, 1, 0);
        pool = {pool, 8'hA5, 8'h02, 8'h01, 8'h02, 8'hFF};
        close_vec(2, 2, 0, 1);
        pool = {pool, 8'hA5, 8'h01, 8'h42, 8'h42};
        close_vec(2, 1, 1, 0);
        pool = {pool, 8'hA5, 8'h00};
        close_vec(2, 0, 0, 1);
        pool = {pool, 8'hA5, 8'h11};
        close_vec(2, 0, 0, 1);
        pool = {pool, 8'h00, 8'h7E, 8'hA5, 8'h02, 8'hA5, 8'h05, 8'hAA};
        close_vec(4, 2, 1, 0);
        pool = {pool, 8'hA5, 8'h02, 8'h01, 8'h02, 8'hFF};
        close_vec(2, 2, 0, 1);
        pool = {pool, 8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) pool.push_back(8'hFF);
        pool.push_back(8'hF0);
        close_vec(2, 16, 1, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_hold", 32'(cpu_hold), 1);
        chk("rst_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 1);

        for (int k = 0; k < vecs.size(); k++) run_vec(k);

        for (int i = 0; i < 16; i++)
            chk($sformatf("ram_rb%0d", i), 32'(ram[i]), 32'hFF);

        // done/hold land two edges after the checksum byte
        clear_wr();
        send(8'hA5);
        send(8'h02);
        send(8'h05);
        send(8'h06);
        send(8'h0B);
        chk("t_eval_ready", 32'(in_ready), 0);
        chk("t_eval_done", 32'(load_done), 0);
        @(posedge clk);
        #1;
        chk("t_k1_done", 32'(load_done), 0);
        chk("t_k1_hold", 32'(cpu_hold), 1);
        @(posedge clk);
        #1;
        chk("t_k2_done", 32'(load_done), 1);
        chk("t_k2_hold", 32'(cpu_hold), 0);

        // byte held during EVAL is taken the cycle after
        clear_wr();
        send(8'hA5);
        send(8'h01);
        send(8'h07);
        send(8'h07);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        chk("h_eval_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("h_after_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear_wr();
        send(8'h01);
        send(8'h09);
        send(8'h09);
        repeat (3) @(posedge clk);
        #1;
        chk("h_done", 32'(load_done), 1);
        chk("h_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("h_addr", 32'(wa[0]), 0);
            chk("h_data", 32'(wd[0]), 32'h09);
        end

        // reset in the middle of DATA
        clear_wr();
        send(8'hA5);
        send(8'h04);
        send(8'h11);
        send(8'h22);
        chk("r_we_before", 32'(ram_we), 1);
        reset = 1'b0;
        #1;
        chk("r_we", 32'(ram_we), 0);
        chk("r_done", 32'(load_done), 0);
        chk("r_hold", 32'(cpu_hold), 1);
        chk("r_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        clear_wr();
        send(8'h33);
        send(8'hA5);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h07);
        repeat (3) @(posedge clk);
        #1;
        chk("r2_done", 32'(load_done), 1);
        chk("r2_err", 32'(load_err), 0);
        chk("r2_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("r2_d0", 32'(wd[0]), 32'h03);
            chk("r2_d1", 32'(wd[1]), 32'h04);
            chk("r2_a1", 32'(wa[1]), 1);
        end

        chk("never_both", 32'(both_seen), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
